// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave slice: default word length, chip-select
// bus width, the fill word sent when no reply is queued, and the slave FSM
// state encoding.
// ----------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_DATALEN = 8;
  localparam int SPI_CS_W    = 3;

  // Word shifted out on MISO when the transmit buffer is empty at LOAD time.
  localparam logic [7:0] SPI_IDLE_FILL = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spiState_t;

endpackage

// File: rtl/spi_slave_if.sv
// ----------------------------------------------------------------------------
// spi_slave_if
// Local-side handshake bundle of the SPI slave.
//   txData    next reply word              (local logic -> slave)
//   txLoad    write txData into tx buffer  (local logic -> slave)
//   txReady   tx buffer empty              (slave -> local logic)
//   rxData    last complete received word  (slave -> local logic)
//   rxValid   rxData not yet acknowledged  (slave -> local logic)
//   rxAck     acknowledge rxData           (local logic -> slave)
//   rxOverrun sticky, word lost            (slave -> local logic)
// Modports: slave (the SPI slave core), master (the local logic).
// ----------------------------------------------------------------------------
interface spi_slave_if
  import spi_pkg::*;
#(
  parameter int DATA_LEN = SPI_DATALEN
);

  logic [DATA_LEN-1:0] txData;
  logic                txLoad;
  logic                txReady;
  logic [DATA_LEN-1:0] rxData;
  logic                rxValid;
  logic                rxAck;
  logic                rxOverrun;

  modport slave (
    input  txData, txLoad, rxAck,
    output txReady, rxData, rxValid, rxOverrun
  );

  modport master (
    output txData, txLoad, rxAck,
    input  txReady, rxData, rxValid, rxOverrun
  );

endinterface

// File: rtl/spi_edge_sync.sv
// ----------------------------------------------------------------------------
// spi_edge_sync
// Brings one asynchronous SPI line into the clk domain through STAGES flops,
// then one more flop that holds the synchronized level and produces
// registered one-cycle rise/fall pulses aligned with that level.
//   clk    system clock
//   rst    asynchronous active-low reset
//   din    asynchronous input line
//   level  synchronized level
//   rise   one-cycle pulse, level went 0 -> 1
//   fall   one-cycle pulse, level went 1 -> 0
// STAGES must be at least 2. RST_VAL is the level assumed during reset; it
// decides whether the line's state at reset release is seen as an edge.
// ----------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] syncPipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncPipe <= {STAGES{RST_VAL}};
      level    <= RST_VAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      syncPipe <= {syncPipe[STAGES-2:0], din};
      // level and the pulses update together so users see a consistent pair
      level    <= syncPipe[STAGES-1];
      rise     <= syncPipe[STAGES-1] & ~level;
      fall     <= ~syncPipe[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave
// Byte-oriented SPI mode 0 (CPOL=0, CPHA=0) slave, MSB first. All SPI inputs
// are oversampled in the clk domain. Received words are handed over with a
// valid/ack handshake; reply words come from a one-entry transmit buffer.
//   clk       system clock (rising edge)
//   rst       asynchronous active-low reset
//   SPI_SCLK  serial clock from the master
//   SPI_CS    active-low chip selects, bit CS_INDEX selects this slave
//   SPI_MOSI  serial data from the master
//   SPI_MISO  serial data to the master
//   bus       local handshake (spi_slave_if.slave)
// Build option SPI_SLAVE_TRISTATE_EN: MISO is released to 'z' while this
// slave is not selected and during reset (shared MISO wire); otherwise MISO
// is driven 0 while deselected.
// ----------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_LEN    = SPI_DATALEN,
  parameter int CS_INDEX    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                SPI_SCLK,
  input  logic [SPI_CS_W-1:0] SPI_CS,
  input  logic                SPI_MOSI,
  output wire                 SPI_MISO,
  spi_slave_if.slave          bus
);

  localparam int              CNT_W    = $clog2(DATA_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);

  logic                sclkLevel, sclkRise, sclkFall;
  logic                csLevel, csRise, csFall;
  logic                sel;
  logic [SYNC_STAGES:0] mosiPipe;
  logic                mosiLevel;

  spiState_t           state, nextState;
  logic                doLoad;
  logic                wordDone;
  logic                txAccept;
  logic                misoEn;

  logic [CNT_W-1:0]    bitCnt;
  logic [DATA_LEN-1:0] txShift;
  logic [DATA_LEN-1:0] txBuf;
  logic                txFull;
  logic [DATA_LEN-1:0] rxShift;
  logic [DATA_LEN-1:0] rxDataR;
  logic                rxValidR;
  logic                rxOverrunR;

  // Input synchronization
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) sclkSync (
    .clk   (clk),
    .rst   (rst),
    .din   (SPI_SCLK),
    .level (sclkLevel),
    .rise  (sclkRise),
    .fall  (sclkFall)
  );

  // CS resets to the asserted level: a CS still low when reset is released
  // produces no fall pulse, so the slave waits for a fresh select.
  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) csSync (
    .clk   (clk),
    .rst   (rst),
    .din   (SPI_CS[CS_INDEX]),
    .level (csLevel),
    .rise  (csRise),
    .fall  (csFall)
  );

  assign sel = ~csLevel;

  // MOSI: same depth as the SCLK path (sync stages + level flop), no edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosiPipe <= '0;
    end else begin
      mosiPipe <= {mosiPipe[SYNC_STAGES-1:0], SPI_MOSI};
    end
  end

  assign mosiLevel = mosiPipe[SYNC_STAGES];

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // The buffer transfer is done on the transition into LOAD, so the first
  // MISO bit is ready SYNC_STAGES+2 cycles after the CS fall at the pin.
  // LOAD is left only once SCLK is low, so a select seen while SCLK is
  // still high cannot count a stray rise.
  always_comb begin
    nextState = state;
    doLoad    = 1'b0;
    if (csRise) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (csFall) begin
            nextState = LOAD;
            doLoad    = 1'b1;
          end
        end
        LOAD: begin
          if (!sclkLevel) nextState = SHIFT;
        end
        SHIFT: begin
          if (sclkFall && (bitCnt == CNT_FULL)) begin
            nextState = LOAD;
            doLoad    = 1'b1;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  assign wordDone = (state == SHIFT) && sclkRise && (bitCnt == CNT_LAST) && !csRise;

  // A LOAD frees the buffer in the same cycle, so a txLoad then is accepted.
  assign txAccept = bus.txLoad && (!txFull || doLoad);

  // Shift registers, bit counter and transmit buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitCnt  <= '0;
      txShift <= '0;
      txBuf   <= '0;
      txFull  <= 1'b0;
      rxShift <= '0;
    end else begin
      if (txAccept) begin
        txBuf  <= bus.txData;
        txFull <= 1'b1;
      end else if (doLoad) begin
        txFull <= 1'b0;
      end

      if (csRise) begin
        bitCnt <= '0;
      end else if (doLoad) begin
        bitCnt  <= '0;
        txShift <= txFull ? txBuf : DATA_LEN'(SPI_IDLE_FILL);
      end else if (state == SHIFT) begin
        if (sclkRise && (bitCnt != CNT_FULL)) begin
          rxShift <= {rxShift[DATA_LEN-2:0], mosiLevel};
          bitCnt  <= bitCnt + 1'b1;
        end
        if (sclkFall) begin
          txShift <= {txShift[DATA_LEN-2:0], 1'b0};
        end
      end
    end
  end

  // Receive handshake: a completion beats a simultaneous rxAck
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxDataR    <= '0;
      rxValidR   <= 1'b0;
      rxOverrunR <= 1'b0;
    end else if (wordDone) begin
      rxDataR  <= {rxShift[DATA_LEN-2:0], mosiLevel};
      rxValidR <= 1'b1;
      if (bus.rxAck) begin
        rxOverrunR <= 1'b0;
      end else if (rxValidR) begin
        rxOverrunR <= 1'b1;
      end
    end else if (bus.rxAck) begin
      rxValidR   <= 1'b0;
      rxOverrunR <= 1'b0;
    end
  end

  assign bus.rxData    = rxDataR;
  assign bus.rxValid   = rxValidR;
  assign bus.rxOverrun = rxOverrunR;
  assign bus.txReady   = ~txFull;

  assign misoEn = sel && (state != IDLE);

`ifdef SPI_SLAVE_TRISTATE_EN
  assign SPI_MISO = misoEn ? txShift[DATA_LEN-1] : 1'bz;
`else
  assign SPI_MISO = misoEn & txShift[DATA_LEN-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave: a table of single-word frames plus
// hand-written sequences for back-to-back words, overrun, aborted words,
// LOAD/txLoad collision, ack/completion collision, a second slave on an
// unused chip select, and asynchronous reset in the middle of a word.
// ----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int HP = 8;  // SCLK half period in clk cycles

  logic       clk;
  logic       rst;
  logic       sclk;
  logic [2:0] cs;
  logic       mosi;
  wire        miso;
  wire        miso2;

  int nChecks;
  int nFails;

  spi_slave_if #(.DATA_LEN(8)) bus ();
  spi_slave_if #(.DATA_LEN(8)) bus2 ();

  spi_slave #(.DATA_LEN(8), .CS_INDEX(0), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .SPI_SCLK (sclk),
    .SPI_CS   (cs),
    .SPI_MOSI (mosi),
    .SPI_MISO (miso),
    .bus      (bus.slave)
  );

  spi_slave #(.DATA_LEN(8), .CS_INDEX(2), .SYNC_STAGES(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .SPI_SCLK (sclk),
    .SPI_CS   (cs),
    .SPI_MOSI (mosi),
    .SPI_MISO (miso2),
    .bus      (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] tx;
    logic       hasTx;
    logic [7:0] mosiByte;
    logic [7:0] expRx;
    logic [7:0] expMiso;
  } vec_t;

  vec_t vecs [4];

  task automatic check1(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadTx(input logic [7:0] d);
    bus.txData = d;
    bus.txLoad = 1'b1;
    tick(1);
    bus.txLoad = 1'b0;
  endtask

  task automatic ackRx();
    bus.rxAck = 1'b1;
    tick(1);
    bus.rxAck = 1'b0;
  endtask

  task automatic csUp();
    tick(HP);
    cs[0] = 1'b1;
    tick(HP);
  endtask

  // Master side of one word (or nBits of it); MISO sampled at each SCLK rise.
  task automatic xfer(input logic [7:0] m, input int nBits, input bit chkLat,
                      input bit ackAtDone, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nBits; i--) begin
      mosi = m[i];
      tick(HP);
      sclk   = 1'b1;
      got[i] = miso;
      if (i == 0 && (chkLat || ackAtDone)) begin
        tick(3);
        if (chkLat) check1("rxLatencyBefore", bus.rxValid, 1'b0);
        if (ackAtDone) bus.rxAck = 1'b1;
        tick(1);
        bus.rxAck = 1'b0;
        if (chkLat) check1("rxLatencyAt", bus.rxValid, 1'b1);
        tick(HP - 4);
      end else begin
        tick(HP);
      end
      sclk = 1'b0;
    end
  endtask

  logic [7:0] got;
  logic [7:0] got2;

  initial begin
    nChecks = 0;
    nFails  = 0;
    rst  = 1'b0;
    sclk = 1'b0;
    cs   = 3'b111;
    mosi = 1'b0;
    bus.txData  = 8'h00;
    bus.txLoad  = 1'b0;
    bus.rxAck   = 1'b0;
    bus2.txData = 8'h00;
    bus2.txLoad = 1'b0;
    bus2.rxAck  = 1'b0;

    vecs[0] = '{8'h3C, 1'b1, 8'hA5, 8'hA5, 8'h3C};
    vecs[1] = '{8'hC3, 1'b1, 8'h0F, 8'h0F, 8'hC3};
    vecs[2] = '{8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{8'h77, 1'b0, 8'h81, 8'h81, 8'h00};

    // Reset state
    tick(3);
    check1("resetMisoInReset", miso, 1'b0);
    check1("resetTxReadyInReset", bus.txReady, 1'b1);
    rst = 1'b1;
    tick(5);
    check1("resetRxValid", bus.rxValid, 1'b0);
    check8("resetRxData", bus.rxData, 8'h00);
    check1("resetOverrun", bus.rxOverrun, 1'b0);
    check1("resetTxReady", bus.txReady, 1'b1);
    check1("resetMiso", miso, 1'b0);
    check8("resetBitCnt", 8'(dut.bitCnt), 8'h00);

    // Single-word frames from the table
    for (int k = 0; k < 4; k++) begin
      if (vecs[k].hasTx) begin
        loadTx(vecs[k].tx);
        check1("txReadyAfterLoad", bus.txReady, 1'b0);
        loadTx(~vecs[k].tx);  // buffer full: must be ignored
      end
      cs[0] = 1'b0;
      xfer(vecs[k].mosiByte, 8, (k == 0), 1'b0, got);
      csUp();
      check8("vecRxData", bus.rxData, vecs[k].expRx);
      check1("vecRxValid", bus.rxValid, 1'b1);
      check1("vecOverrun", bus.rxOverrun, 1'b0);
      check8("vecMiso", got, vecs[k].expMiso);
      check1("vecTxReady", bus.txReady, 1'b1);
      check1("vecMisoDeselected", miso, 1'b0);
      check1("vecOtherSlaveValid", bus2.rxValid, 1'b0);
      ackRx();
      check1("vecAckClears", bus.rxValid, 1'b0);
    end

    // Back-to-back words in one frame, acked each
    cs[0] = 1'b0;
    xfer(8'h01, 8, 1'b0, 1'b0, got);
    check8("b2bFirstData", bus.rxData, 8'h01);
    check1("b2bFirstValid", bus.rxValid, 1'b1);
    check8("b2bFirstMiso", got, 8'h00);
    ackRx();
    check1("b2bFirstAcked", bus.rxValid, 1'b0);
    xfer(8'h02, 8, 1'b0, 1'b0, got);
    check8("b2bSecondData", bus.rxData, 8'h02);
    check1("b2bSecondValid", bus.rxValid, 1'b1);
    check1("b2bNoOverrun", bus.rxOverrun, 1'b0);
    ackRx();
    csUp();

    // Two words without ack: overrun
    cs[0] = 1'b0;
    xfer(8'h3A, 8, 1'b0, 1'b0, got);
    xfer(8'hC5, 8, 1'b0, 1'b0, got);
    csUp();
    check8("ovrData", bus.rxData, 8'hC5);
    check1("ovrValid", bus.rxValid, 1'b1);
    check1("ovrFlag", bus.rxOverrun, 1'b1);
    ackRx();
    check1("ovrAckValid", bus.rxValid, 1'b0);
    check1("ovrAckFlag", bus.rxOverrun, 1'b0);

    // Aborted word, then a full word with an empty tx buffer
    cs[0] = 1'b0;
    xfer(8'hFF, 5, 1'b0, 1'b0, got);
    csUp();
    check1("abortNoValid", bus.rxValid, 1'b0);
    check8("abortBitCnt", 8'(dut.bitCnt), 8'h00);
    cs[0] = 1'b0;
    xfer(8'h55, 8, 1'b0, 1'b0, got);
    csUp();
    check8("abortNextData", bus.rxData, 8'h55);
    check1("abortNextValid", bus.rxValid, 1'b1);
    check8("abortNextMiso", got, 8'h00);
    ackRx();

    // txLoad coinciding with LOAD, then ack coinciding with completion
    loadTx(8'h22);
    check1("collTxReadyFull", bus.txReady, 1'b0);
    cs[0] = 1'b0;
    tick(3);
    bus.txData = 8'h11;
    bus.txLoad = 1'b1;
    tick(1);
    bus.txLoad = 1'b0;
    check1("collTxReadyHeld", bus.txReady, 1'b0);
    xfer(8'h5A, 8, 1'b0, 1'b0, got);
    check8("collFirstMiso", got, 8'h22);
    check1("otherSlaveMiso", miso2, 1'b0);
    check1("collFirstValid", bus.rxValid, 1'b1);
    xfer(8'hC3, 8, 1'b0, 1'b1, got2);
    check8("collSecondMiso", got2, 8'h11);
    check1("ackCollValid", bus.rxValid, 1'b1);
    check1("ackCollOverrun", bus.rxOverrun, 1'b0);
    check8("ackCollData", bus.rxData, 8'hC3);
    check1("collTxReadyBack", bus.txReady, 1'b1);
    csUp();
    ackRx();
    check1("collAckValid", bus.rxValid, 1'b0);
    check1("otherSlaveNoValid", bus2.rxValid, 1'b0);
    check1("otherSlaveTxReady", bus2.txReady, 1'b1);

    // Asynchronous reset in the middle of a word
    cs[0] = 1'b0;
    xfer(8'h96, 8, 1'b0, 1'b0, got);
    check1("rstPreValid", bus.rxValid, 1'b1);
    xfer(8'hF0, 3, 1'b0, 1'b0, got);
    #2;
    rst = 1'b0;
    #1;
    check1("rstAsyncValid", bus.rxValid, 1'b0);
    check8("rstAsyncData", bus.rxData, 8'h00);
    check8("rstAsyncBitCnt", 8'(dut.bitCnt), 8'h00);
    check1("rstAsyncMiso", miso, 1'b0);
    tick(2);
    rst = 1'b1;
    tick(2);
    xfer(8'hAA, 8, 1'b0, 1'b0, got);
    check1("rstNoWordWithoutSelect", bus.rxValid, 1'b0);
    csUp();
    cs[0] = 1'b0;
    xfer(8'h3A, 8, 1'b0, 1'b0, got);
    csUp();
    check8("rstFreshData", bus.rxData, 8'h3A);
    check1("rstFreshValid", bus.rxValid, 1'b1);
    ackRx();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
